// File: rtl/upht_updater.sv
// uPHT updater: queues resolved-branch commits and performs a two-stage
// read-modify-write of the 2-bit saturating counters in the uPHT. The read
// stage borrows the shared read port when prediction is not using it. The
// write stage computes the new counter and forwards it to a back-to-back
// read of the same index, because the table is not yet updated at that point.
module upht_updater #(
  parameter int SAT_TABLE_SIZE = 64,
  parameter int FIFO_DEPTH     = 4,
  localparam int AW = $clog2(SAT_TABLE_SIZE),
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_commit_vld,
  input  logic [AW-1:0] i_commit_addr,
  input  logic          i_commit_taken,
  output logic          o_commit_rdy,
  input  logic          i_rdport_busy,
  input  logic          i_uPht_enable,
  output logic          o_uPhtRead_vld,
  output logic [AW-1:0] o_uPhtRd_addr,
  input  logic [1:0]    i_uPhtRd_Cnt,
  output logic          o_uPhtWrite_vld,
  output logic [AW-1:0] o_uPhtWr_addr,
  output logic [1:0]    o_commit_Cnt,
  output logic          o_idle
);

  function automatic logic [1:0] sat_update(input logic [1:0] base, input logic taken);
    if (taken) begin
      return (base == 2'b11) ? 2'b11 : base + 2'd1;
    end
    return (base == 2'b00) ? 2'b00 : base - 2'd1;
  endfunction

  logic [AW-1:0] r_fifo_addr  [FIFO_DEPTH];
  logic          r_fifo_taken [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          r_vld_p1;
  logic [AW-1:0] r_addr_p1;
  logic          r_taken_p1;
  logic [1:0]    r_base_p1;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_rd_fire;
  logic [AW-1:0] w_head_addr;
  logic          w_head_taken;
  logic          w_bypass;
  logic [1:0]    w_base_p0;
  logic [1:0]    w_cnt_p1;

  // Commit queue: occupancy comes from registers only, so a full queue never
  // accepts even if an entry leaves in the same cycle.
  assign w_full       = (r_count == CW'(FIFO_DEPTH));
  assign w_empty      = (r_count == '0);
  assign o_commit_rdy = !i_rst && !w_full;
  assign w_push       = i_commit_vld && o_commit_rdy;
  assign w_head_addr  = r_fifo_addr[r_rd_ptr];
  assign w_head_taken = r_fifo_taken[r_rd_ptr];

  // ---- stage p0: read of the uPHT and pop of the queue head ----
  assign w_rd_fire      = !w_empty && !i_rdport_busy && i_uPht_enable;
  assign o_uPhtRead_vld = w_rd_fire;
  assign o_uPhtRd_addr  = w_rd_fire ? w_head_addr : '0;
  assign w_bypass       = r_vld_p1 && (r_addr_p1 == w_head_addr);
  assign w_base_p0      = w_bypass ? w_cnt_p1 : i_uPhtRd_Cnt;

  // ---- stage p1: counter update and write strobe ----
  assign w_cnt_p1        = sat_update(r_base_p1, r_taken_p1);
  assign o_commit_Cnt    = w_cnt_p1;
  assign o_uPhtWrite_vld = r_vld_p1 && i_uPht_enable;
  assign o_uPhtWr_addr   = r_addr_p1;
  assign o_idle          = w_empty && !r_vld_p1;

  // Queue storage, pointers and occupancy; push and pop together leave the count as is.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_addr[i]  <= '0;
        r_fifo_taken[i] <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_fifo_addr[r_wr_ptr]  <= i_commit_addr;
        r_fifo_taken[r_wr_ptr] <= i_commit_taken;
        r_wr_ptr               <= r_wr_ptr + PW'(1);
      end
      if (w_rd_fire) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_rd_fire})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Write-stage register: loads from a firing read, drains otherwise, and
  // freezes entirely while the uPHT is disabled.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vld_p1   <= 1'b0;
      r_addr_p1  <= '0;
      r_taken_p1 <= 1'b0;
      r_base_p1  <= 2'b00;
    end else if (i_uPht_enable) begin
      r_vld_p1 <= w_rd_fire;
      if (w_rd_fire) begin
        r_addr_p1  <= w_head_addr;
        r_taken_p1 <= w_head_taken;
        r_base_p1  <= w_base_p0;
      end
    end
  end

endmodule
